// File: rtl/jtkiwi_vout_pkg.sv
// Shared constants and types for the Kiwi video output stage.
package jtkiwi_vout_pkg;

    localparam int CIN_W  = 5;
    localparam int COUT_W = 8;
    localparam int CNT_W  = 9;
    localparam logic [CNT_W-1:0] CNT_SAT = 9'd511;

    typedef enum logic [1:0] {
        PAT_PASS  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_WHITE = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        LK_INIT = 2'd0,
        LK_ONE  = 2'd1,
        LK_RUN  = 2'd2
    } lk_e;

    typedef struct packed {
        logic [COUT_W-1:0] r;
        logic [COUT_W-1:0] g;
        logic [COUT_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
    } sync_t;

    function automatic logic [COUT_W-1:0] expand(input logic [CIN_W-1:0] c);
        return {c, c[CIN_W-1 -: 3]};
    endfunction

endpackage

// File: rtl/jtkiwi_vout_meas.sv
// Sync edge detection plus line/frame length measurement and timing lock flag.
module jtkiwi_vout_meas
    import jtkiwi_vout_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pxl_cen,
    input  logic             lhbl,
    input  logic             lvbl,
    input  logic             hs,
    input  logic             vs,
    output logic             lhbl_rise,
    output logic             lvbl_rise,
    output logic [CNT_W-1:0] hlen,
    output logic [CNT_W-1:0] vlen,
    output logic             locked
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 9'd1;
    endfunction

    sync_t            prev;
    logic             hs_rise, vs_rise;
    logic [CNT_W-1:0] hcnt, vcnt, hlen_prev, vlen_prev, hlen_new;
    logic             match, lock_nxt;
    lk_e              lk_st, lk_nxt;

    assign lhbl_rise = lhbl & ~prev.lhbl;
    assign lvbl_rise = lvbl & ~prev.lvbl;
    assign hs_rise   = hs   & ~prev.hs;
    assign vs_rise   = vs   & ~prev.vs;

    // A line ending on the same cen as the frame must count in this frame's comparison
    always_comb begin
        hlen_new = hs_rise ? hcnt : hlen;
        match    = (hlen_new == hlen_prev) && (vcnt == vlen_prev) &&
                   (hlen_new != CNT_SAT) && (vcnt != CNT_SAT);
        lk_nxt   = lk_st;
        lock_nxt = locked;
        if (vs_rise) begin
            case (lk_st)
                LK_INIT: begin lk_nxt = LK_ONE; lock_nxt = 1'b0;  end
                LK_ONE:  begin lk_nxt = LK_RUN; lock_nxt = 1'b0;  end
                default: begin lk_nxt = LK_RUN; lock_nxt = match; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            hlen      <= '0;
            vlen      <= '0;
            hlen_prev <= '0;
            vlen_prev <= '0;
            lk_st     <= LK_INIT;
            locked    <= 1'b0;
        end else if (pxl_cen) begin
            prev   <= '{lhbl: lhbl, lvbl: lvbl, hs: hs, vs: vs};
            lk_st  <= lk_nxt;
            locked <= lock_nxt;
            if (hs_rise) begin
                hlen <= hcnt;
                hcnt <= 9'd1;
            end else begin
                hcnt <= sat_inc(hcnt);
            end
            if (vs_rise) begin
                vlen      <= vcnt;
                vcnt      <= hs_rise ? 9'd1 : 9'd0;
                hlen_prev <= hlen_new;
                vlen_prev <= vcnt;
            end else if (hs_rise) begin
                vcnt <= sat_inc(vcnt);
            end
        end
    end

endmodule

// File: rtl/jtkiwi_vout.sv
// Kiwi video output: sync-aligned pixel pipeline, colour expansion, test patterns, blanking.
// Optional scanline dimming is built when JTKIWI_SCANLINE_EN is defined.
module jtkiwi_vout
    import jtkiwi_vout_pkg::*;
#(
    parameter int PIPE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pxl_cen,
    input  logic              LHBL,
    input  logic              LVBL,
    input  logic              HS,
    input  logic              VS,
    input  logic [CIN_W-1:0]  red,
    input  logic [CIN_W-1:0]  green,
    input  logic [CIN_W-1:0]  blue,
    input  logic [1:0]        pat_sel,
    input  logic              scan_en,
    output logic [COUT_W-1:0] r8,
    output logic [COUT_W-1:0] g8,
    output logic [COUT_W-1:0] b8,
    output logic              LHBL_o,
    output logic              LVBL_o,
    output logic              HS_o,
    output logic              VS_o,
    output logic              de,
    output logic [CNT_W-1:0]  hlen,
    output logic [CNT_W-1:0]  vlen,
    output logic              locked
);

`ifdef JTKIWI_SCANLINE_EN
    function automatic logic [COUT_W-1:0] dim75(input logic [COUT_W-1:0] c);
        return c - (c >> 2);
    endfunction
`else
    logic unused_scan_en;
    assign unused_scan_en = scan_en;
`endif

    logic             lhbl_rise, lvbl_rise;
    logic [CNT_W-1:0] hpos, vline, hpos_nxt, vline_nxt;
    pat_e             pat;
    rgb_t             pat_rgb, mix_rgb;
    rgb_t             rgb_p  [PIPE];
    sync_t            sync_p [PIPE];

    jtkiwi_vout_meas u_meas (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .lhbl      (LHBL),
        .lvbl      (LVBL),
        .hs        (HS),
        .vs        (VS),
        .lhbl_rise (lhbl_rise),
        .lvbl_rise (lvbl_rise),
        .hlen      (hlen),
        .vlen      (vlen),
        .locked    (locked)
    );

    // The pixel entering on an LHBL rise is hpos 0, so patterns use the next-state position
    always_comb begin
        hpos_nxt  = lhbl_rise ? '0 : hpos + 9'd1;
        vline_nxt = vline;
        if (lvbl_rise)      vline_nxt = '0;
        else if (lhbl_rise) vline_nxt = vline + 9'd1;

        pat     = pat_e'(pat_sel);
        pat_rgb = '{r: expand(red), g: expand(green), b: expand(blue)};
        case (pat)
            PAT_BARS:  pat_rgb = '{r: {COUT_W{hpos_nxt[5]}},
                                   g: {COUT_W{hpos_nxt[6]}},
                                   b: {COUT_W{hpos_nxt[7]}}};
            PAT_GRID:  pat_rgb = {3{((hpos_nxt[3:0] == 4'd0) || (vline_nxt[3:0] == 4'd0))
                                    ? 8'hFF : 8'h00}};
            PAT_WHITE: pat_rgb = '1;
            default:   ;
        endcase

        mix_rgb = pat_rgb;
`ifdef JTKIWI_SCANLINE_EN
        if (scan_en && vline_nxt[0])
            mix_rgb = '{r: dim75(pat_rgb.r), g: dim75(pat_rgb.g), b: dim75(pat_rgb.b)};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos  <= '0;
            vline <= '0;
            for (int i = 0; i < PIPE; i++) begin
                rgb_p[i]  <= '0;
                sync_p[i] <= '0;
            end
        end else if (pxl_cen) begin
            hpos  <= hpos_nxt;
            vline <= vline_nxt;
            // stage 1: pattern/dimmed colour joins the sync bits
            rgb_p[0]  <= mix_rgb;
            sync_p[0] <= '{lhbl: LHBL, lvbl: LVBL, hs: HS, vs: VS};
            // stages 2..PIPE: plain delay
            for (int i = 1; i < PIPE; i++) begin
                rgb_p[i]  <= rgb_p[i-1];
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    // output: blanking applied on the aligned data-enable
    assign LHBL_o = sync_p[PIPE-1].lhbl;
    assign LVBL_o = sync_p[PIPE-1].lvbl;
    assign HS_o   = sync_p[PIPE-1].hs;
    assign VS_o   = sync_p[PIPE-1].vs;
    assign de     = LHBL_o & LVBL_o;
    assign r8     = de ? rgb_p[PIPE-1].r : '0;
    assign g8     = de ? rgb_p[PIPE-1].g : '0;
    assign b8     = de ? rgb_p[PIPE-1].b : '0;

endmodule

// File: tb/tb_jtkiwi_vout.sv
// Scoreboard bench for jtkiwi_vout: per-pixel expected outputs queued at drive time.
module tb_jtkiwi_vout;

    localparam int PIPE = 2;

    logic       clk = 1'b0;
    logic       rst, pxl_cen, LHBL, LVBL, HS, VS, scan_en;
    logic [4:0] red, green, blue;
    logic [1:0] pat_sel;
    logic [7:0] r8, g8, b8;
    logic       LHBL_o, LVBL_o, HS_o, VS_o, de, locked;
    logic [8:0] hlen, vlen;

    jtkiwi_vout #(.PIPE(PIPE)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .red(red), .green(green), .blue(blue),
        .pat_sel(pat_sel), .scan_en(scan_en),
        .r8(r8), .g8(g8), .b8(b8),
        .LHBL_o(LHBL_o), .LVBL_o(LVBL_o), .HS_o(HS_o), .VS_o(VS_o), .de(de),
        .hlen(hlen), .vlen(vlen), .locked(locked)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [28:0] exp_q[$];
    logic [28:0] exp_last;
    bit          have_exp = 0;
    int          cen_cnt  = 0;
    bit          hs_en    = 1;
    bit          chk_h511 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [28:0] out_vec();
        return {r8, g8, b8, LHBL_o, LVBL_o, HS_o, VS_o, de};
    endfunction

    function automatic logic [7:0] exp8(input logic [4:0] c);
        logic [7:0] v;
        v = {c, 3'b000};
        v[2:0] = c[4:2];
        return v;
    endfunction

    function automatic logic [28:0] model(input logic lh, lv, hs_i, vs_i,
                                          input logic [4:0] r, g, b,
                                          input logic [1:0] ps, input logic sc,
                                          input int hp, input int vl);
        logic [8:0] h9, v9;
        logic [7:0] cr, cg, cb;
        h9 = hp[8:0];
        v9 = vl[8:0];
        case (ps)
            2'd0: begin cr = exp8(r); cg = exp8(g); cb = exp8(b); end
            2'd1: begin
                cr = h9[5] ? 8'hFF : 8'h00;
                cg = h9[6] ? 8'hFF : 8'h00;
                cb = h9[7] ? 8'hFF : 8'h00;
            end
            2'd2: begin
                cr = (h9[3:0] == 0 || v9[3:0] == 0) ? 8'hFF : 8'h00;
                cg = cr; cb = cr;
            end
            default: begin cr = 8'hFF; cg = 8'hFF; cb = 8'hFF; end
        endcase
`ifdef JTKIWI_SCANLINE_EN
        if (sc && v9[0]) begin
            cr = cr - cr / 4; cg = cg - cg / 4; cb = cb - cb / 4;
        end
`endif
        if (!(lh && lv)) begin cr = 0; cg = 0; cb = 0; end
        return {cr, cg, cb, lh, lv, hs_i, vs_i, lh & lv};
    endfunction

    task automatic pixel(input logic lh, lv, hs_i, vs_i, input logic [4:0] r, g, b,
                         input logic [1:0] ps, input logic sc, input int hp, input int vl);
        LHBL = lh; LVBL = lv; HS = hs_i; VS = vs_i;
        red = r; green = g; blue = b; pat_sel = ps; scan_en = sc;
        pxl_cen = 1'b1;
        exp_q.push_back(model(lh, lv, hs_i, vs_i, r, g, b, ps, sc, hp, vl));
        @(posedge clk); #1;
        if (exp_q.size() == PIPE) begin
            exp_last = exp_q.pop_front();
            have_exp = 1;
            check("pixel", {3'b0, out_vec()}, {3'b0, exp_last});
        end
        cen_cnt++;
        if (cen_cnt % 8 == 0) begin
            pxl_cen = 1'b0;
            LHBL = ~lh; LVBL = ~lv; HS = ~hs_i; VS = ~vs_i;
            red = ~r; pat_sel = ~ps;
            @(posedge clk); #1;
            if (have_exp) check("hold", {3'b0, out_vec()}, {3'b0, exp_last});
        end
    endtask

    task automatic run_frame(input int H, HA, HS0, V, VA, VS0, mode, stop_px);
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                logic       lh, lv, hs_i, vs_i, sc;
                logic [4:0] r, g, b;
                logic [1:0] ps;
                if (stop_px >= 0 && v * H + h >= stop_px) return;
                lh   = (h < HA);
                lv   = (v < VA);
                hs_i = hs_en && (h >= HS0) && (h < HS0 + 4);
                vs_i = (v == VS0 && h >= HS0) || (v == VS0 + 1) || (v == VS0 + 2 && h < HS0);
                r = 5'($urandom_range(31));
                g = 5'($urandom_range(31));
                b = 5'($urandom_range(31));
                ps = 2'd0; sc = 1'b0;
                case (mode)
                    0: begin
                        if (!(lh && lv)) r = 5'h1F;
                        if (v == 1 && h == 5) r = 5'h10;
                    end
                    1: ps = 2'd1;
                    2: ps = 2'd2;
                    3: begin ps = 2'd3; sc = 1'b1; end
                    4: begin ps = 2'($urandom_range(3)); sc = 1'($urandom_range(1)); end
                    default: begin ps = 2'd3; sc = 1'($urandom_range(1)); end
                endcase
                pixel(lh, lv, hs_i, vs_i, r, g, b, ps, sc, h, v);
                if (chk_h511 && v == 0 && h == HS0) begin
                    check("hlen_sat", 32'(hlen), 511);
                    chk_h511 = 0;
                end
            end
        end
    endtask

    task automatic main_frame(input int H, mode);
        run_frame(H, 256, 264, 12, 8, 9, mode, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 0; LVBL = 0; HS = 0; VS = 0;
        red = 0; green = 0; blue = 0; pat_sel = 0; scan_en = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {3'b0, out_vec()}, 0);
        check("rst_hlen", 32'(hlen), 0);
        check("rst_vlen", 32'(vlen), 0);
        check("rst_locked", 32'(locked), 0);
        rst = 1'b0;

        main_frame(300, 0);
        check("f0_locked", 32'(locked), 0);
        check("f0_hlen", 32'(hlen), 300);
        check("f0_vlen", 32'(vlen), 9);
        main_frame(300, 1);
        check("f1_locked", 32'(locked), 0);
        check("f1_vlen", 32'(vlen), 12);
        main_frame(300, 2);
        check("f2_locked", 32'(locked), 1);
        check("f2_vlen", 32'(vlen), 12);
        check("f2_hlen", 32'(hlen), 300);
        main_frame(301, 3);
        check("long_locked", 32'(locked), 0);
        check("long_hlen", 32'(hlen), 301);
        main_frame(300, 4);
        check("relock1_locked", 32'(locked), 0);
        check("relock1_hlen", 32'(hlen), 300);
        main_frame(300, 0);
        check("relock2_locked", 32'(locked), 1);
        hs_en = 0;
        main_frame(300, 5);
        check("nohs_locked", 32'(locked), 0);
        check("nohs_vlen", 32'(vlen), 3);
        check("nohs_hlen", 32'(hlen), 300);
        hs_en = 1;
        chk_h511 = 1;
        main_frame(300, 3);
        check("hsback_locked", 32'(locked), 0);
        check("hsback_vlen", 32'(vlen), 9);

        run_frame(300, 256, 264, 12, 8, 9, 0, 2 * 300 + 100);
        rst = 1'b1; pxl_cen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pxl_cen = 1'b0;
        exp_q.delete();
        have_exp = 0;
        check("midrst_out", {3'b0, out_vec()}, 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_hlen", 32'(hlen), 0);
        check("midrst_vlen", 32'(vlen), 0);

        for (int f = 0; f < 3; f++) begin
            run_frame(16, 8, 10, 264, 256, 258, 0, -1);
            if (f == 1) begin
                check("tall_vlen", 32'(vlen), 264);
                check("tall_hlen", 32'(hlen), 16);
                check("tall_locked2", 32'(locked), 0);
            end
        end
        check("tall_locked3", 32'(locked), 1);

        run_frame(384, 320, 330, 6, 2, 3, 1, -1);
        check("wide_hlen", 32'(hlen), 384);
        check("wide_locked", 32'(locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
